alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Multi-pass sequencer for the 8-bit ALU datapath: the two 4-bit slices plus the flag generator.
- Accepts one operation of BYTES×8 bits over a valid/ready handshake.
- Drives the ALU one byte per cycle, low byte first, chaining carry between passes.
- Assembles the wide result, accumulates the 8-bit flag word and holds both until the consumer accepts them.
- Sits between the instruction decoder and the register file / flag register.

Parameters:
BYTES, 2, number of 8-bit passes per operation; legal 1..4; operand/result width W = 8*BYTES.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst_n  in  1  synchronous, active-low reset.
op_valid  in  1  request carries a new operation.
op_ready  out  1  sequencer can accept an operation (IDLE only).
op_a  in  W  operand A.
op_b  in  W  operand B.
op_s  in  4  ALU function select.
op_m  in  1  ALU mode (1 = logic, 0 = arithmetic).
op_cn_n  in  1  carry-in to first pass, active-low.
alu_a  out  8  byte of A presented to ALU.
alu_b  out  8  byte of B presented to ALU.
alu_s  out  4  function select to ALU.
alu_m  out  1  mode to ALU.
alu_cn_n  out  1  carry-in to ALU, active-low.
alu_f  in  8  ALU result byte (combinational from alu_* outputs).
alu_flags  in  8  per-pass flag word. Bit layout: 0 Z, 1 C, 2 E, 3 LT, 4 GT, 5 H, 6-7 zero.
alu_cn8_n  in  1  ALU carry-out, active-low.
res_valid  out  1  result/flags available.
res_ready  in  1  consumer accepts result.
res_f  out  W  assembled result.
res_flags  out  8  accumulated flag word.

Behaviour:
- States:
  - IDLE: op_ready=1.
  - RUN: pass counter p = 0..BYTES-1.
  - DONE: res_valid=1.
- Reset (rst_n=0 at clk edge), from any state including mid-RUN or DONE:
  - state=IDLE, p=0.
  - res_f=0, res_flags=0, res_valid=0.
  - All latched operands cleared.
  - No partial result survives.
- IDLE: on op_valid & op_ready, latch op_a, op_b, op_s, op_m, op_cn_n; go to RUN with p=0.
- RUN, one cycle per pass:
  - alu_a = A[8p+7:8p], alu_b = B[8p+7:8p].
  - alu_s, alu_m = latched values.
  - alu_cn_n = latched op_cn_n when p=0, else registered alu_cn8_n from pass p-1.
  - At the edge, store alu_f into res_f[8p+7:8p] and update the flag accumulator.
  - p increments; after pass BYTES-1, go to DONE.
- Outside RUN: alu_a=0, alu_b=0, alu_s=0, alu_m=0, alu_cn_n=1.
- Flag accumulation (internal; published to res_flags on entering DONE):
  - Z = AND of bit0 over all passes.
  - E = AND of bit2 over all passes.
  - C = bit1 of last pass.
  - LT, GT = bits 3, 4 of last pass.
  - H = bit5 of pass 0.
  - Bits 6, 7 = 0.
  - Z and E accumulators preset to 1 on accept.
- Latency: accept edge = cycle 0; passes occupy cycles 1..BYTES; res_valid rises in cycle BYTES+1.
- DONE:
  - res_f and res_flags are stable while res_valid=1.
  - On res_ready, go to IDLE; res_valid drops next cycle.
  - res_f and res_flags keep their last values until the next completion.
- op_ready=0 in RUN and DONE; op_valid there is ignored, not queued.
- res_ready and op_valid in the same DONE cycle: only the completion is taken; op_ready rises next cycle. Peak throughput is one op per BYTES+2 cycles.
- res_ready outside DONE has no effect.

Decomposition:
- Package alu_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - flag bit index constants FLAG_Z, FLAG_C, FLAG_E, FLAG_LT, FLAG_GT, FLAG_H;
  - function-select constants (ALU_ADD = 4'b1001, ALU_SUB = 4'b0110).
- One natural sub-module, alu_flag_acc: per-pass flag accumulation and Z/E preset, with clear/accumulate/first/last controls.

Test Plan (BYTES=2 unless noted; bench wires a behavioural two-slice ALU and flag generator to alu_*):
1. ADD 0x00FF + 0x0001, s=1001, m=0, cn_n=1 -> pass1 alu_cn_n=0; res_f=0x0100; res_flags Z=0, C=0, H=1; res_valid in cycle 3.
2. ADD 0xFFFF + 0x0001, cn_n=1 -> res_f=0x0000; Z=1, C=1.
3. SUB-minus-1 0x1234 - 0x1234, s=0110, m=0, cn_n=1 -> res_f=0xFFFF; E=1, Z=0.
4. res_ready held low 5 cycles after completion, op_valid pulsed meanwhile -> res_f/res_flags stable, op_ready=0, pulsed op never executed.
5. rst_n low during pass 1 of 0xFFFF+0x0001 -> next cycle IDLE, res_valid=0, res_f=0, res_flags=0; following op 0x0002+0x0003 returns 0x0005.
6. BYTES=1: ADD 0xF0 + 0x20, cn_n=1 -> res_f=0x10, C=1, res_valid in cycle 2.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the multi-pass ALU sequencer
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the per-pass and accumulated flag words
  localparam int FLAG_Z  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_E  = 2;
  localparam int FLAG_LT = 3;
  localparam int FLAG_GT = 4;
  localparam int FLAG_H  = 5;

  localparam logic [3:0] ALU_ADD = 4'b1001;
  localparam logic [3:0] ALU_SUB = 4'b0110;

endpackage

// File: rtl/alu_flag_acc.sv
// rtl/alu_flag_acc.sv - folds per-pass ALU flags into one flag word for a wide operation
module alu_flag_acc
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_acc,
  input  logic       i_first,
  input  logic       i_last,
  input  logic [7:0] i_flags,
  output logic [7:0] o_flags_next
);

  logic r_z, r_e, r_c, r_lt, r_gt, r_h;
  logic w_z, w_e, w_c, w_lt, w_gt, w_h;
  logic w_unused_flags;

  assign w_unused_flags = ^i_flags[7:6];

  // Z/E span every pass, H comes from the low byte, C/LT/GT from the high byte
  always_comb begin
    w_z  = r_z & i_flags[FLAG_Z];
    w_e  = r_e & i_flags[FLAG_E];
    w_h  = i_first ? i_flags[FLAG_H]  : r_h;
    w_c  = i_last  ? i_flags[FLAG_C]  : r_c;
    w_lt = i_last  ? i_flags[FLAG_LT] : r_lt;
    w_gt = i_last  ? i_flags[FLAG_GT] : r_gt;
    o_flags_next          = 8'h00;
    o_flags_next[FLAG_Z]  = w_z;
    o_flags_next[FLAG_C]  = w_c;
    o_flags_next[FLAG_E]  = w_e;
    o_flags_next[FLAG_LT] = w_lt;
    o_flags_next[FLAG_GT] = w_gt;
    o_flags_next[FLAG_H]  = w_h;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_z  <= 1'b0;
      r_e  <= 1'b0;
      r_c  <= 1'b0;
      r_lt <= 1'b0;
      r_gt <= 1'b0;
      r_h  <= 1'b0;
    end else if (i_clear) begin
      r_z  <= 1'b1;
      r_e  <= 1'b1;
      r_c  <= 1'b0;
      r_lt <= 1'b0;
      r_gt <= 1'b0;
      r_h  <= 1'b0;
    end else if (i_acc) begin
      r_z  <= w_z;
      r_e  <= w_e;
      r_c  <= w_c;
      r_lt <= w_lt;
      r_gt <= w_gt;
      r_h  <= w_h;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - drives an 8-bit ALU one byte per cycle to execute a BYTES-wide operation
module alu_seq
  import alu_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [8*BYTES-1:0]   op_a,
  input  logic [8*BYTES-1:0]   op_b,
  input  logic [3:0]           op_s,
  input  logic                 op_m,
  input  logic                 op_cn_n,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_cn_n,
  input  logic [7:0]           alu_f,
  input  logic [7:0]           alu_flags,
  input  logic                 alu_cn8_n,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [8*BYTES-1:0]   res_f,
  output logic [7:0]           res_flags
);

  localparam int W = 8 * BYTES;

  state_t         r_state;
  logic [2:0]     r_p;
  logic [W-1:0]   r_a, r_b, r_acc_f;
  logic [3:0]     r_s;
  logic           r_m, r_cn_n, r_cn8_n;
  logic [W-1:0]   w_f_next;
  logic [7:0]     w_flags_next;
  logic           w_run, w_last, w_accept;

  assign w_run     = (r_state == RUN);
  assign w_last    = (r_p == 3'(BYTES - 1));
  assign w_accept  = (r_state == IDLE) && op_valid;
  assign op_ready  = (r_state == IDLE);
  assign res_valid = (r_state == DONE);

  always_comb begin
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    alu_s    = w_run ? r_s : 4'h0;
    alu_m    = w_run ? r_m : 1'b0;
    alu_cn_n = w_run ? ((r_p == 3'd0) ? r_cn_n : r_cn8_n) : 1'b1;
    w_f_next = r_acc_f;
    for (int i = 0; i < BYTES; i++) begin
      if (w_run && r_p == 3'(i)) begin
        alu_a              = r_a[8*i +: 8];
        alu_b              = r_b[8*i +: 8];
        w_f_next[8*i +: 8] = alu_f;
      end
    end
  end

  alu_flag_acc u_flag_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_accept),
    .i_acc        (w_run),
    .i_first      (r_p == 3'd0),
    .i_last       (w_last),
    .i_flags      (alu_flags),
    .o_flags_next (w_flags_next)
  );

  // res_f/res_flags only change on completion, so they hold through the next op's RUN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_p       <= 3'd0;
      r_a       <= '0;
      r_b       <= '0;
      r_s       <= 4'h0;
      r_m       <= 1'b0;
      r_cn_n    <= 1'b0;
      r_cn8_n   <= 1'b1;
      r_acc_f   <= '0;
      res_f     <= '0;
      res_flags <= 8'h00;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (op_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_s     <= op_s;
            r_m     <= op_m;
            r_cn_n  <= op_cn_n;
            r_p     <= 3'd0;
            r_acc_f <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc_f <= w_f_next;
          r_cn8_n <= alu_cn8_n;
          if (w_last) begin
            res_f     <= w_f_next;
            res_flags <= w_flags_next;
            r_p       <= 3'd0;
            r_state   <= DONE;
          end else begin
            r_p <= r_p + 3'd1;
          end
        end
        DONE: begin
          if (res_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed bench for alu_seq with a behavioural byte ALU and flag generator
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, op_valid, op_ready, op_m, op_cn_n;
  logic [15:0] op_a, op_b, res_f;
  logic [3:0]  op_s, alu_s;
  logic [7:0]  alu_a, alu_b, alu_f, alu_flags, res_flags;
  logic        alu_m, alu_cn_n, alu_cn8_n, res_valid, res_ready;

  logic        d1_op_valid, d1_op_ready, d1_op_m, d1_op_cn_n;
  logic [7:0]  d1_op_a, d1_op_b, d1_res_f, d1_alu_a, d1_alu_b, d1_alu_f, d1_alu_flags, d1_res_flags;
  logic [3:0]  d1_op_s, d1_alu_s;
  logic        d1_alu_m, d1_alu_cn_n, d1_alu_cn8_n, d1_res_valid, d1_res_ready;

  int total = 0;
  int bad   = 0;

  // Two 4-bit slices modelled as one byte: returns {cn8_n, flags, f}
  function automatic logic [16:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] s, input logic m, input logic cn_n);
    logic [8:0] sum;
    logic [4:0] nib;
    logic [7:0] bb, f;
    logic       c, h;
    if (m) begin
      f = (s == 4'b0110) ? (a ^ b) : (a & b);
      c = 1'b0;
      h = 1'b0;
    end else begin
      bb  = (s == ALU_SUB) ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {8'h00, ~cn_n};
      nib = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'h0, ~cn_n};
      f   = sum[7:0];
      c   = sum[8];
      h   = nib[4];
    end
    return {~c, 2'b00, h, (a > b), (a < b), (f == 8'hFF), c, (f == 8'h00), f};
  endfunction

  always_comb {alu_cn8_n, alu_flags, alu_f} = alu_model(alu_a, alu_b, alu_s, alu_m, alu_cn_n);
  always_comb {d1_alu_cn8_n, d1_alu_flags, d1_alu_f} =
      alu_model(d1_alu_a, d1_alu_b, d1_alu_s, d1_alu_m, d1_alu_cn_n);

  alu_seq #(.BYTES(2)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cn_n(op_cn_n),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn_n(alu_cn_n),
    .alu_f(alu_f), .alu_flags(alu_flags), .alu_cn8_n(alu_cn8_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_f(res_f), .res_flags(res_flags)
  );

  alu_seq #(.BYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .op_valid(d1_op_valid), .op_ready(d1_op_ready),
    .op_a(d1_op_a), .op_b(d1_op_b), .op_s(d1_op_s), .op_m(d1_op_m), .op_cn_n(d1_op_cn_n),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_s(d1_alu_s), .alu_m(d1_alu_m), .alu_cn_n(d1_alu_cn_n),
    .alu_f(d1_alu_f), .alu_flags(d1_alu_flags), .alu_cn8_n(d1_alu_cn8_n),
    .res_valid(d1_res_valid), .res_ready(d1_res_ready), .res_f(d1_res_f), .res_flags(d1_res_flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one op to the BYTES=2 instance and waits until res_valid; leaves it in DONE
  task automatic run2(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                      input logic m, input logic cn, output int lat,
                      output logic cn0, output logic cn1);
    int n;
    n = 0;
    while (!op_ready && n < 20) begin tick(); n++; end
    chk("op_ready_before_op", op_ready, 1);
    op_valid = 1'b1; op_a = a; op_b = b; op_s = s; op_m = m; op_cn_n = cn;
    tick();
    op_valid = 1'b0;
    lat = 1;
    cn0 = alu_cn_n;
    cn1 = 1'bx;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
      if (lat == 2) cn1 = alu_cn_n;
    end
  endtask

  task automatic finish2;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 0);
    chk("op_ready_return", op_ready, 1);
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  s;
    logic        m, cn;
    logic [15:0] f;
    logic [7:0]  fl;
    logic        cn1;
  } vec_t;

  vec_t vt[6];

  initial begin
    int   lat;
    logic c0, c1, seen;
    vt[0] = '{16'h00FF, 16'h0001, ALU_ADD, 1'b0, 1'b1, 16'h0100, 8'h20, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, ALU_ADD, 1'b0, 1'b1, 16'h0000, 8'h33, 1'b0};
    vt[2] = '{16'h1234, 16'h1234, ALU_SUB, 1'b0, 1'b1, 16'hFFFF, 8'h04, 1'b1};
    vt[3] = '{16'h1234, 16'h1111, ALU_ADD, 1'b0, 1'b1, 16'h2345, 8'h10, 1'b1};
    vt[4] = '{16'h0007, 16'h0008, ALU_ADD, 1'b0, 1'b0, 16'h0010, 8'h20, 1'b1};
    vt[5] = '{16'hF0F0, 16'h0FF0, 4'b0110, 1'b1, 1'b1, 16'hFF00, 8'h10, 1'b1};

    rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cn_n = 1'b1;
    res_ready = 1'b0;
    d1_op_valid = 1'b0; d1_op_a = '0; d1_op_b = '0; d1_op_s = '0; d1_op_m = 1'b0;
    d1_op_cn_n = 1'b1; d1_res_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_op_ready", op_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_f", res_f, 0);
    chk("rst_res_flags", res_flags, 0);
    chk("rst_alu_cn_n", alu_cn_n, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_d1_op_ready", d1_op_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run2(vt[i].a, vt[i].b, vt[i].s, vt[i].m, vt[i].cn, lat, c0, c1);
      chk($sformatf("v%0d_latency", i), lat, 3);
      chk($sformatf("v%0d_res_f", i), res_f, vt[i].f);
      chk($sformatf("v%0d_res_flags", i), res_flags, vt[i].fl);
      chk($sformatf("v%0d_pass0_cn_n", i), c0, vt[i].cn);
      chk($sformatf("v%0d_pass1_cn_n", i), c1, vt[i].cn1);
      finish2();
    end

    // Consumer stalls while a new op is offered; it must be dropped, not queued
    run2(16'h1234, 16'h1111, ALU_ADD, 1'b0, 1'b1, lat, c0, c1);
    chk("hold_latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin op_valid = 1'b1; op_a = 16'h0101; op_b = 16'h0101; end
      tick();
      op_valid = 1'b0;
      chk($sformatf("hold%0d_res_valid", k), res_valid, 1);
      chk($sformatf("hold%0d_op_ready", k), op_ready, 0);
      chk($sformatf("hold%0d_res_f", k), res_f, 16'h2345);
      chk($sformatf("hold%0d_res_flags", k), res_flags, 8'h10);
    end
    op_valid = 1'b1; res_ready = 1'b1;
    tick();
    op_valid = 1'b0; res_ready = 1'b0;
    chk("both_res_valid", res_valid, 0);
    chk("both_op_ready", op_ready, 1);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin tick(); if (res_valid || !op_ready) seen = 1'b1; end
    chk("dropped_op_not_run", seen, 0);
    chk("idle_keeps_res_f", res_f, 16'h2345);
    chk("idle_keeps_res_flags", res_flags, 8'h10);

    // Reset during the second pass wipes everything
    op_valid = 1'b1; op_a = 16'hFFFF; op_b = 16'h0001; op_s = ALU_ADD; op_m = 1'b0; op_cn_n = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    chk("mid_run_busy", op_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_op_ready", op_ready, 1);
    chk("midrst_res_f", res_f, 0);
    chk("midrst_res_flags", res_flags, 0);
    run2(16'h0002, 16'h0003, ALU_ADD, 1'b0, 1'b1, lat, c0, c1);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_res_f", res_f, 16'h0005);
    chk("post_rst_res_flags", res_flags, 8'h00);
    finish2();

    // Single-pass instance
    d1_op_valid = 1'b1; d1_op_a = 8'hF0; d1_op_b = 8'h20; d1_op_s = ALU_ADD; d1_op_m = 1'b0;
    d1_op_cn_n = 1'b1;
    tick();
    d1_op_valid = 1'b0;
    chk("d1_pass0_cn_n", d1_alu_cn_n, 1);
    lat = 1;
    while (!d1_res_valid && lat < 20) begin tick(); lat++; end
    chk("d1_latency", lat, 2);
    chk("d1_res_f", d1_res_f, 8'h10);
    chk("d1_res_flags", d1_res_flags, 8'h12);
    d1_res_ready = 1'b1;
    tick();
    d1_res_ready = 1'b0;
    chk("d1_res_valid_drop", d1_res_valid, 0);
    chk("d1_op_ready_return", d1_op_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
